// File: rtl/lv_pwm_code_decode_if.sv
// Line and status bundle between the HV PWM receiver pin and the LV pulse-count decoder.
interface lv_pwm_code_decode_if #(
    parameter int CODE_W = 3
);
    logic              i_pwm_n;
    logic              i_en;
    logic              o_pwm_gwave;
    logic              o_code_vld;
    logic [CODE_W-1:0] o_code;
    logic              o_intb_n;
    logic              o_intb_set;
    logic              o_intb_clr;
    logic              o_err;
    logic [1:0]        o_err_type;
    logic              o_busy;

    modport master (
        output i_pwm_n, i_en,
        input  o_pwm_gwave, o_code_vld, o_code, o_intb_n, o_intb_set, o_intb_clr,
               o_err, o_err_type, o_busy
    );

    modport slave (
        input  i_pwm_n, i_en,
        output o_pwm_gwave, o_code_vld, o_code, o_intb_n, o_intb_set, o_intb_clr,
               o_err, o_err_type, o_busy
    );
endinterface

// File: rtl/lv_pwm_code_decode.sv
// Pulse-count decoder for the HV-to-LV PWM interrupt line: filters low pulses, counts
// qualified ones into gap-terminated frames, and drives the HV interrupt level.
//
// state   | meaning
// IDLE    | no frame open, waiting for a qualified pulse
// COUNT   | frame open, counting qualified pulses until the gap timeout
// DRAIN   | frame discarded after overflow/long pulse, waiting for a quiet gap
// WAIT_HI | long low in progress, waiting for the line to return high
module lv_pwm_code_decode #(
    parameter int CNT_W     = 5,
    parameter int PW_MIN    = 4,
    parameter int PW_MAX    = 8,
    parameter int GAP_TO    = 9,
    parameter int MAX_PULSE = 4,
    parameter int SYNC_STG  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    lv_pwm_code_decode_if.slave  bus
);
    localparam int CODE_W = $clog2(MAX_PULSE + 1);

    localparam logic [CNT_W-1:0]  LW_MIN = CNT_W'(PW_MIN);
    localparam logic [CNT_W-1:0]  LW_MAX = CNT_W'(PW_MAX);
    localparam logic [CNT_W-1:0]  LW_SAT = CNT_W'(PW_MAX + 1);
    localparam logic [CNT_W-1:0]  GC_TO  = CNT_W'(GAP_TO);
    localparam logic [CODE_W-1:0] PC_MAX = CODE_W'(MAX_PULSE);
    localparam logic [CODE_W-1:0] PC_ONE = CODE_W'(1);

    typedef enum logic [1:0] {IDLE, COUNT, DRAIN, WAIT_HI} state_t;

    state_t              state_q, state_d;
    logic [SYNC_STG-1:0] sync_q, sync_d;
    logic                s_prev_q;
    logic [CNT_W-1:0]    lw_q, lw_d;
    logic [CNT_W-1:0]    gc_q, gc_d;
    logic                long_seen_q, long_seen_d;
    logic [CODE_W-1:0]   pc_q, pc_d;
    logic                code_vld_q, code_vld_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                intb_n_q, intb_n_d;
    logic                set_q, set_d;
    logic                clr_q, clr_d;
    logic                err_q, err_d;
    logic [1:0]          err_type_q, err_type_d;
    logic                busy_q, busy_d;

    logic s, rise, qual, long_ev;

    assign s       = sync_q[SYNC_STG-1];
    assign rise    = s & ~s_prev_q;
    assign qual    = rise && (lw_q >= LW_MIN) && (lw_q <= LW_MAX);
    // long_seen keeps a saturated low run from raising the error more than once
    assign long_ev = bus.i_en && (lw_q == LW_SAT) && !long_seen_q;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = bus.i_pwm_n;
        for (int i = 1; i < SYNC_STG; i++) begin
            sync_d[i] = sync_q[i-1];
        end

        state_d     = state_q;
        pc_d        = pc_q;
        lw_d        = s ? '0 : ((lw_q != LW_SAT) ? lw_q + CNT_W'(1) : lw_q);
        long_seen_d = !s && (lw_q == LW_SAT);
        if (qual) begin
            gc_d = CNT_W'(1);
        end else if (s && (gc_q != GC_TO)) begin
            gc_d = gc_q + CNT_W'(1);
        end else begin
            gc_d = gc_q;
        end
        code_vld_d = 1'b0;
        code_d     = code_q;
        intb_n_d   = intb_n_q;
        set_d      = 1'b0;
        clr_d      = 1'b0;
        err_d      = 1'b0;
        err_type_d = err_type_q;

        if (!bus.i_en) begin
            state_d     = IDLE;
            lw_d        = '0;
            gc_d        = '0;
            pc_d        = '0;
            long_seen_d = 1'b0;
        end else if (long_ev) begin
            state_d    = WAIT_HI;
            pc_d       = '0;
            err_d      = 1'b1;
            err_type_d = 2'b01;
        end else begin
            case (state_q)
                IDLE: begin
                    if (qual) begin
                        state_d = COUNT;
                        pc_d    = PC_ONE;
                    end
                end
                COUNT: begin
                    if (qual) begin
                        if (pc_q == PC_MAX) begin
                            state_d    = DRAIN;
                            pc_d       = '0;
                            err_d      = 1'b1;
                            err_type_d = 2'b10;
                        end else begin
                            pc_d = pc_q + PC_ONE;
                        end
                    end else if (gc_q == GC_TO) begin
                        state_d    = IDLE;
                        pc_d       = '0;
                        code_vld_d = 1'b1;
                        code_d     = pc_q;
                        if (pc_q == PC_ONE) begin
                            intb_n_d = 1'b0;
                            set_d    = 1'b1;
                        end
                        if (pc_q == PC_MAX) begin
                            intb_n_d = 1'b1;
                            clr_d    = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!qual && (gc_q == GC_TO)) begin
                        state_d = IDLE;
                    end
                end
                WAIT_HI: begin
                    if (s) begin
                        state_d = DRAIN;
                        gc_d    = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q      <= '1;
            s_prev_q    <= 1'b1;
            lw_q        <= '0;
            gc_q        <= '0;
            long_seen_q <= 1'b0;
            pc_q        <= '0;
            state_q     <= IDLE;
            code_vld_q  <= 1'b0;
            code_q      <= '0;
            intb_n_q    <= 1'b1;
            set_q       <= 1'b0;
            clr_q       <= 1'b0;
            err_q       <= 1'b0;
            err_type_q  <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            s_prev_q    <= s;
            lw_q        <= lw_d;
            gc_q        <= gc_d;
            long_seen_q <= long_seen_d;
            pc_q        <= pc_d;
            state_q     <= state_d;
            code_vld_q  <= code_vld_d;
            code_q      <= code_d;
            intb_n_q    <= intb_n_d;
            set_q       <= set_d;
            clr_q       <= clr_d;
            err_q       <= err_d;
            err_type_q  <= err_type_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.o_pwm_gwave = s;
    assign bus.o_code_vld  = code_vld_q;
    assign bus.o_code      = code_q;
    assign bus.o_intb_n    = intb_n_q;
    assign bus.o_intb_set  = set_q;
    assign bus.o_intb_clr  = clr_q;
    assign bus.o_err       = err_q;
    assign bus.o_err_type  = err_type_q;
    assign bus.o_busy      = busy_q;
endmodule
